// File: rtl/car_lane_if.sv
// car_lane_if: bus between the game/VGA side and one lane controller
interface car_lane_if;
  logic        i_Game_Active;
  logic        i_Pause;
  logic [3:0]  i_Level;
  logic [9:0]  i_Lane_Y;
  logic [9:0]  i_Col_Count_Div;
  logic [9:0]  i_Row_Count_Div;
  logic [9:0]  i_Frog_X;
  logic [9:0]  i_Frog_Y;
  logic        o_Draw_Car;
  logic        o_Hit;
  logic [10:0] o_Base_X;
  modport master (
    output i_Game_Active, i_Pause, i_Level, i_Lane_Y, i_Col_Count_Div, i_Row_Count_Div, i_Frog_X, i_Frog_Y,
    input  o_Draw_Car, o_Hit, o_Base_X
  );
  modport slave (
    input  i_Game_Active, i_Pause, i_Level, i_Lane_Y, i_Col_Count_Div, i_Row_Count_Div, i_Frog_X, i_Frog_Y,
    output o_Draw_Car, o_Hit, o_Base_X
  );
endinterface

// File: rtl/car_lane_ctrl.sv
// car_lane_ctrl: moves a lane of cars, renders their sprite pixels and flags frog collisions
module car_lane_ctrl #(
  parameter int c_GAME_WIDTH       = 640,
  parameter int c_NUM_CARS         = 3,
  parameter int c_CAR_WIDTH        = 64,
  parameter int c_CAR_HEIGHT       = 32,
  parameter int c_SPACING          = 234,
  parameter int c_DIRECTION        = 0,
  parameter int c_INITIAL_POSITION = 0,
  parameter int c_BASE_SPEED       = 1650000,
  parameter int c_SPEED_STEP       = 150000,
  parameter int c_MIN_SPEED        = 200000,
  parameter int c_FROG_SIZE        = 32
) (
  input logic       i_Clk,
  input logic       i_Reset,
  car_lane_if.slave bus
);
  localparam int WR  = c_GAME_WIDTH + c_CAR_WIDTH;
  localparam int RCW = $clog2(c_CAR_WIDTH);
  localparam int RRW = $clog2(c_CAR_HEIGHT);
  localparam int AW  = $clog2(c_CAR_WIDTH * c_CAR_HEIGHT);
  localparam logic [10:0] c_WR  = 11'(WR);
  localparam logic [10:0] c_W   = 11'(c_GAME_WIDTH);
  localparam logic [10:0] c_CW  = 11'(c_CAR_WIDTH);
  localparam logic [10:0] c_CH  = 11'(c_CAR_HEIGHT);
  localparam logic [10:0] c_FS  = 11'(c_FROG_SIZE);
  localparam logic [10:0] c_INI = 11'(c_INITIAL_POSITION);
  // Body with a cabin cut-out over the rear half; asymmetric so mirroring is visible
  function automatic logic [c_CAR_WIDTH*c_CAR_HEIGHT-1:0] init_rom();
    logic [c_CAR_WIDTH*c_CAR_HEIGHT-1:0] r;
    r = '0;
    for (int y = 0; y < c_CAR_HEIGHT; y++)
      for (int x = 0; x < c_CAR_WIDTH; x++)
        r[y*c_CAR_WIDTH+x] = y >= 4 && y < c_CAR_HEIGHT-4 && x >= 2 &&
                             x < c_CAR_WIDTH-2-(y < c_CAR_HEIGHT/2 ? c_CAR_WIDTH/4 : 0);
    return r;
  endfunction
  localparam logic [c_CAR_WIDTH*c_CAR_HEIGHT-1:0] c_ROM = init_rom();
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state, state_n;
  logic [31:0] cnt, per, per_calc, dec;
  logic [10:0] base, base_nxt, lane_y, col, row, fx, fy, sel_pos, rel_c;
  logic [10:0] pos [c_NUM_CARS];
  logic [c_NUM_CARS-1:0] cov, hit_k;
  logic step, s1_on, draw, hit;
  logic [RCW-1:0] rc, s1_rc;
  logic [RRW-1:0] s1_rr;
  logic [AW-1:0] idx;
  assign col = {1'b0, bus.i_Col_Count_Div};
  assign row = {1'b0, bus.i_Row_Count_Div};
  assign fx  = {1'b0, bus.i_Frog_X};
  assign fy  = {1'b0, bus.i_Frog_Y};
  assign dec = 32'(bus.i_Level) * 32'(c_SPEED_STEP);
  assign per_calc = (dec < 32'(c_BASE_SPEED) && 32'(c_BASE_SPEED) - dec > 32'(c_MIN_SPEED))
                    ? 32'(c_BASE_SPEED) - dec : 32'(c_MIN_SPEED);
  assign step = state == RUN && cnt == per - 32'd1;
  assign base_nxt = c_DIRECTION != 0 ? (base == 11'd0 ? c_WR - 11'd1 : base - 11'd1)
                                     : (base == c_WR - 11'd1 ? 11'd0 : base + 11'd1);
  always_comb state_n = !bus.i_Game_Active ? IDLE : state == IDLE ? RUN : bus.i_Pause ? PAUSED : RUN;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state  <= IDLE;
      base   <= c_INI;
      cnt    <= '0;
      lane_y <= {1'b0, bus.i_Lane_Y};
      per    <= per_calc;
    end else begin
      state <= state_n;
      if (state == IDLE || state_n == IDLE) lane_y <= {1'b0, bus.i_Lane_Y};
      if (state == IDLE || step) per <= per_calc;
      if (state_n == IDLE) begin
        base <= c_INI;
        cnt  <= '0;
      end else if (state == RUN) begin
        cnt <= step ? '0 : cnt + 32'd1;
        if (step) base <= base_nxt;
      end
    end
  end
  for (genvar k = 0; k < c_NUM_CARS; k++) begin : g_car
    logic [10:0] sum;
    assign sum      = base + 11'(k * c_SPACING);
    assign pos[k]   = sum >= c_WR ? sum - c_WR : sum;
    assign cov[k]   = col + c_CW >= pos[k] && col < pos[k] && col < c_W && row >= lane_y && row < lane_y + c_CH;
    assign hit_k[k] = fx < pos[k] && fx + c_FS + c_CW > pos[k] && fy < lane_y + c_CH && fy + c_FS > lane_y;
  end
  // Scan downward so the lowest-index covering car is the last one written
  always_comb begin
    sel_pos = '0;
    for (int k = c_NUM_CARS - 1; k >= 0; k--) sel_pos = cov[k] ? pos[k] : sel_pos;
  end
  assign rel_c = col + c_CW - sel_pos;
  assign rc    = c_DIRECTION != 0 ? RCW'(c_CAR_WIDTH - 1) - RCW'(rel_c) : RCW'(rel_c);
  assign idx   = AW'(s1_rr) * AW'(c_CAR_WIDTH) + AW'(s1_rc);
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      s1_on <= 1'b0;
      s1_rc <= '0;
      s1_rr <= '0;
      draw  <= 1'b0;
      hit   <= 1'b0;
    end else begin
      s1_on <= |cov;
      s1_rc <= rc;
      s1_rr <= RRW'(row - lane_y);
      draw  <= s1_on && c_ROM[idx];
      hit   <= state != IDLE && |hit_k;
    end
  end
  assign bus.o_Draw_Car = draw;
  assign bus.o_Hit      = hit;
  assign bus.o_Base_X   = base;
endmodule
